// File: rtl/bpu_btb_ras_pkg.sv
// Package: bpu_btb_ras_pkg
// Shared definitions for the branch predictor and its users (EXU encodes
// resolved control-flow types with the same codes).
//  - control-flow type codes (upd_type encoding)
//  - 2-bit saturating counter state constants
//  - counter step and type-normalisation helpers
package bpu_btb_ras_pkg;

  // Control-flow type codes carried on upd_type and stored per BTB entry.
  localparam logic [1:0] TYPE_BRA  = 2'b00;  // branch / JAL / JALR
  localparam logic [1:0] TYPE_CALL = 2'b01;
  localparam logic [1:0] TYPE_RET  = 2'b10;
  localparam logic [1:0] TYPE_RSV  = 2'b11;  // reserved, behaves as BRA

  // Saturating counter states.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // One saturating step towards the resolved direction.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

  // The reserved code is stored as BRA so that later lookups never see it.
  function automatic logic [1:0] norm_type(input logic [1:0] t);
    return (t == TYPE_RSV) ? TYPE_BRA : t;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Module: bpu_ras
// Commit-updated return-address stack (circular buffer).
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  clear        empty the stack (flush); wins over push/pop
//  push, pop    commit-time push of push_pc / pop of the top entry
//  push_pc      return address to push
//  top_pc       current top entry (meaningful when !empty)
//  empty        no valid entries
// top points at the most recent entry. A push when full overwrites the
// oldest entry; a pop when empty is ignored; push+pop together replaces the
// top entry (or acts as a plain push when empty).
module bpu_ras #(
  parameter  int PC_W      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_pc,
  output logic [PC_W-1:0] top_pc,
  output logic            empty
);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PC_W-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_inc;

  assign top_inc = top_q + PTR_W'(1);
  assign top_pc  = mem_q[top_q];
  assign empty   = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (clear) begin
      top_d = '0;
      cnt_d = '0;
    end else if (push && (!pop || empty)) begin
      top_d          = top_inc;
      mem_d[top_inc] = push_pc;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (push && pop) begin
      mem_d[top_q] = push_pc;
    end else if (pop && !empty) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bpu_btb_ras.sv
// Module: bpu_btb_ras
// Branch predictor between the IFU fetch-PC stage and EXU resolve:
// fully-associative BTB with 2-bit counters plus a commit-updated RAS.
// Build option: define BPU_RAS_EN to include the return-address stack;
// without it RET entries predict their stored target like BRA and the
// upd_ras_* inputs are ignored.
// Ports:
//  clk, rst                    clock, synchronous active-high reset
//  req_valid/req_ready/req_pc  lookup request
//  resp_valid/resp_ready       registered response handshake
//  resp_hit/taken/target/idx   prediction (target 0 when not taken,
//                              idx = alloc pointer on a miss)
//  upd_*                       resolved control-flow instruction from EXU
//  flush_all                   invalidate BTB, clear RAS (fence.i)
// Handshake: a transfer happens on a cycle where valid && ready are both
// high; the response holds its outputs stable while resp_valid && !resp_ready,
// and req_ready = !resp_valid || resp_ready.
module bpu_btb_ras
  import bpu_btb_ras_pkg::*;
#(
  parameter  int PC_W      = 32,
  parameter  int BTB_DEPTH = 8,
  parameter  int RAS_DEPTH = 4,
  localparam int IDX_W     = $clog2(BTB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PC_W-1:0]  req_pc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic             resp_taken,
  output logic [PC_W-1:0]  resp_target,
  output logic [IDX_W-1:0] resp_idx,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_taken,
  input  logic [1:0]       upd_type,
  input  logic             upd_ras_push,
  input  logic             upd_ras_pop,
  input  logic [PC_W-1:0]  upd_ras_pc,
  input  logic             flush_all
);

  // BTB storage
  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [PC_W-1:0]      tag_q  [BTB_DEPTH];
  logic [PC_W-1:0]      tag_d  [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_q  [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_d  [BTB_DEPTH];
  logic [1:0]           type_q [BTB_DEPTH];
  logic [1:0]           type_d [BTB_DEPTH];
  logic [1:0]           ctr_q  [BTB_DEPTH];
  logic [1:0]           ctr_d  [BTB_DEPTH];
  logic [IDX_W-1:0]     alloc_q, alloc_d;

  // Response registers
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_taken_q, resp_taken_d;
  logic [PC_W-1:0]  resp_target_q, resp_target_d;
  logic [IDX_W-1:0] resp_idx_q, resp_idx_d;

  logic             lk_hit, lk_taken;
  logic [IDX_W-1:0] lk_idx;
  logic [PC_W-1:0]  lk_target;
  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       u_type;
  logic             accept;

`ifdef BPU_RAS_EN
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;

  bpu_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush_all),
    .push    (upd_valid && upd_ras_push),
    .pop     (upd_valid && upd_ras_pop),
    .push_pc (upd_ras_pc),
    .top_pc  (ras_top),
    .empty   (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{upd_ras_push, upd_ras_pop, upd_ras_pc, type_q[lk_idx]};
`endif

  assign req_ready   = !resp_valid_q || resp_ready;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_taken  = resp_taken_q;
  assign resp_target = resp_target_q;
  assign resp_idx    = resp_idx_q;

  // CAM searches; scanning from the top down leaves the lowest match.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = alloc_q;
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = BTB_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_pc)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == upd_pc)) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = tgt_q[lk_idx];
`ifdef BPU_RAS_EN
    if (type_q[lk_idx] == TYPE_RET) begin
      lk_target = ras_top;
      if (ras_empty) lk_taken = 1'b0;
    end
`endif
    if (!lk_taken) lk_target = '0;
  end

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_hit_d    = resp_hit_q;
    resp_taken_d  = resp_taken_q;
    resp_target_d = resp_target_q;
    resp_idx_d    = resp_idx_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_hit_d    = lk_hit;
      resp_taken_d  = lk_taken;
      resp_target_d = lk_target;
      resp_idx_d    = lk_idx;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // BTB update; flush overrides any same-cycle update.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    type_d  = type_q;
    ctr_d   = ctr_q;
    alloc_d = alloc_q;
    u_type  = norm_type(upd_type);
    if (flush_all) begin
      valid_d = '0;
      alloc_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        tgt_d[upd_idx]  = upd_target;
        type_d[upd_idx] = u_type;
        ctr_d[upd_idx]  = (u_type == TYPE_BRA) ? ctr_step(ctr_q[upd_idx], upd_taken) : CTR_ST;
      end else if (upd_taken) begin
        valid_d[alloc_q] = 1'b1;
        tag_d[alloc_q]   = upd_pc;
        tgt_d[alloc_q]   = upd_target;
        type_d[alloc_q]  = u_type;
        ctr_d[alloc_q]   = (u_type == TYPE_BRA) ? CTR_WT : CTR_ST;
        alloc_d          = alloc_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      tag_q         <= '{default: '0};
      tgt_q         <= '{default: '0};
      type_q        <= '{default: '0};
      ctr_q         <= '{default: '0};
      alloc_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_taken_q  <= 1'b0;
      resp_target_q <= '0;
      resp_idx_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      type_q        <= type_d;
      ctr_q         <= ctr_d;
      alloc_q       <= alloc_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_taken_q  <= resp_taken_d;
      resp_target_q <= resp_target_d;
      resp_idx_q    <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Testbench for bpu_btb_ras (default parameters: PC_W=32, BTB_DEPTH=8,
// RAS_DEPTH=4). Expected RAS-dependent results follow BPU_RAS_EN.
module tb_bpu_btb_ras;

  localparam int PC_W  = 32;
  localparam int IDX_W = 3;
  localparam int W     = 2 + PC_W + IDX_W;
`ifdef BPU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam logic [1:0] T_BRA  = 2'b00;
  localparam logic [1:0] T_CALL = 2'b01;
  localparam logic [1:0] T_RET  = 2'b10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [PC_W-1:0]  req_pc = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic             resp_hit;
  logic             resp_taken;
  logic [PC_W-1:0]  resp_target;
  logic [IDX_W-1:0] resp_idx;
  logic             upd_valid = 1'b0;
  logic [PC_W-1:0]  upd_pc = '0;
  logic [PC_W-1:0]  upd_target = '0;
  logic             upd_taken = 1'b0;
  logic [1:0]       upd_type = '0;
  logic             upd_ras_push = 1'b0;
  logic             upd_ras_pop = 1'b0;
  logic [PC_W-1:0]  upd_ras_pc = '0;
  logic             flush_all = 1'b0;

  bpu_btb_ras dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pc       (req_pc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_hit     (resp_hit),
    .resp_taken   (resp_taken),
    .resp_target  (resp_target),
    .resp_idx     (resp_idx),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_type     (upd_type),
    .upd_ras_push (upd_ras_push),
    .upd_ras_pop  (upd_ras_pop),
    .upd_ras_pc   (upd_ras_pc),
    .flush_all    (flush_all)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic hit, input logic taken,
                                      input logic [PC_W-1:0] tgt, input logic [IDX_W-1:0] idx);
    return {hit, taken, tgt, idx};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  // Sampled mid-cycle: a response is consumed at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", 64'd1, 64'd0);
        end else begin
          check_eq(tag_q.pop_front(), 64'({resp_hit, resp_taken, resp_target, resp_idx}),
                   64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_lookup(input string tag, input logic [PC_W-1:0] pc, input logic [W-1:0] exp);
    int n;
    req_valid = 1'b1;
    req_pc    = pc;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        check_eq("req_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input logic taken,
                        input logic [1:0] typ, input logic push, input logic pop,
                        input logic [PC_W-1:0] rpc);
    upd_valid    = 1'b1;
    upd_pc       = pc;
    upd_target   = tgt;
    upd_taken    = taken;
    upd_type     = typ;
    upd_ras_push = push;
    upd_ras_pop  = pop;
    upd_ras_pc   = rpc;
    @(posedge clk); #1;
    upd_valid    = 1'b0;
    upd_ras_push = 1'b0;
    upd_ras_pop  = 1'b0;
  endtask

  // RAS-only commit: the PC never allocates because it is not taken.
  task automatic ras_op(input logic push, input logic pop, input logic [PC_W-1:0] rpc);
    do_upd(32'hF00, 32'h0, 1'b0, T_BRA, push, pop, rpc);
  endtask

  task automatic do_flush();
    flush_all = 1'b1;
    @(posedge clk); #1;
    flush_all = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tag_q.delete();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] ret_live, ret_dead;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_vec", 64'({resp_hit, resp_taken, resp_target, resp_idx}), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);

    // 1: cold lookup misses
    do_lookup("cold_miss", 32'h100, mk(0, 0, 0, 0));

    // 2: allocate BRA, then counter walk
    do_upd(32'h100, 32'h200, 1'b1, T_BRA, 0, 0, 0);
    do_lookup("bra_alloc", 32'h100, mk(1, 1, 32'h200, 0));
    do_upd(32'h100, 32'h200, 1'b0, T_BRA, 0, 0, 0);
    do_upd(32'h100, 32'h200, 1'b0, T_BRA, 0, 0, 0);
    do_lookup("bra_ctr00", 32'h100, mk(1, 0, 0, 0));
    do_upd(32'h100, 32'h200, 1'b0, T_BRA, 0, 0, 0);
    do_lookup("bra_sat_low", 32'h100, mk(1, 0, 0, 0));
    do_upd(32'h100, 32'h200, 1'b1, T_BRA, 0, 0, 0);
    do_lookup("bra_ctr01", 32'h100, mk(1, 0, 0, 0));
    do_upd(32'h100, 32'h200, 1'b1, T_BRA, 0, 0, 0);
    do_upd(32'h100, 32'h240, 1'b1, T_BRA, 0, 0, 0);
    do_upd(32'h100, 32'h240, 1'b1, T_BRA, 0, 0, 0);
    do_lookup("bra_sat_high", 32'h100, mk(1, 1, 32'h240, 0));

    // 3: CALL pushes, RET uses RAS top
    do_upd(32'h180, 32'h400, 1'b1, T_CALL, 1, 0, 32'h104);
    do_lookup("call_alloc", 32'h180, mk(1, 1, 32'h400, 1));
    do_upd(32'h300, 32'h555, 1'b1, T_RET, 0, 0, 0);
    ret_dead = RAS_ON ? mk(1, 0, 0, 2) : mk(1, 1, 32'h555, 2);
    ret_live = mk(1, 1, 32'h555, 2);
    do_lookup("ret_top", 32'h300, RAS_ON ? mk(1, 1, 32'h104, 2) : ret_live);
    ras_op(0, 1, 0);
    do_lookup("ret_empty", 32'h300, ret_dead);

    // 4: overflow then drain the 4-deep RAS
    for (int i = 1; i <= 5; i++) ras_op(1, 0, 32'(i * 16));
    do_lookup("ras_pop0", 32'h300, RAS_ON ? mk(1, 1, 32'h50, 2) : ret_live);
    for (int i = 0; i < 3; i++) begin
      ras_op(0, 1, 0);
      do_lookup($sformatf("ras_pop%0d", i + 1), 32'h300,
                RAS_ON ? mk(1, 1, 32'(32'h40 - 16 * i), 2) : ret_live);
    end
    ras_op(0, 1, 0);
    do_lookup("ras_drained", 32'h300, ret_dead);
    ras_op(0, 1, 0);
    do_lookup("ras_underflow", 32'h300, ret_dead);
    ras_op(1, 0, 32'h60);
    do_lookup("ras_push_after_empty", 32'h300, RAS_ON ? mk(1, 1, 32'h60, 2) : ret_live);
    ras_op(1, 1, 32'h70);
    do_lookup("ras_pushpop_replace", 32'h300, RAS_ON ? mk(1, 1, 32'h70, 2) : ret_live);
    ras_op(0, 1, 0);
    do_lookup("ras_pushpop_count", 32'h300, ret_dead);
    ras_op(1, 1, 32'h80);
    do_lookup("ras_pushpop_empty", 32'h300, RAS_ON ? mk(1, 1, 32'h80, 2) : ret_live);
    wait_drain();

    // 6: backpressure holds the response and blocks new requests
    resp_ready = 1'b0;
    do_lookup("stall_a", 32'h180, mk(1, 1, 32'h400, 1));
    req_valid = 1'b1;
    req_pc    = 32'h100;
    exp_q.push_back(mk(1, 1, 32'h240, 0));
    tag_q.push_back("stall_b");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_req_ready", 64'(req_ready), 64'd0);
      check_eq("stall_resp_stable", 64'({resp_valid, resp_hit, resp_taken, resp_target, resp_idx}),
               64'({1'b1, mk(1, 1, 32'h400, 1)}));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();

    // flush wins over a same-cycle update and RAS push
    flush_all    = 1'b1;
    upd_valid    = 1'b1;
    upd_pc       = 32'h2000;
    upd_target   = 32'h2100;
    upd_taken    = 1'b1;
    upd_type     = T_BRA;
    upd_ras_push = 1'b1;
    upd_ras_pc   = 32'h90;
    @(posedge clk); #1;
    flush_all    = 1'b0;
    upd_valid    = 1'b0;
    upd_ras_push = 1'b0;
    do_lookup("flush_old", 32'h100, mk(0, 0, 0, 0));
    do_lookup("flush_vs_upd", 32'h2000, mk(0, 0, 0, 0));
    do_upd(32'h300, 32'h666, 1'b1, T_RET, 0, 0, 0);
    do_lookup("flush_ras_cleared", 32'h300, RAS_ON ? mk(1, 0, 0, 0) : mk(1, 1, 32'h666, 0));

    // 5: BTB_DEPTH+1 allocations wrap the alloc pointer
    do_flush();
    for (int i = 0; i < 9; i++) do_upd(32'(32'h1000 + 4 * i), 32'(32'h5000 + 4 * i), 1'b1, T_BRA, 0, 0, 0);
    do_lookup("wrap_first_evicted", 32'h1000, mk(0, 0, 0, 1));
    do_lookup("wrap_entry0_last", 32'h1020, mk(1, 1, 32'h5020, 0));
    do_lookup("wrap_entry1", 32'h1004, mk(1, 1, 32'h5004, 1));
    do_lookup("wrap_entry7", 32'h101C, mk(1, 1, 32'h501C, 7));
    // Random re-probes of surviving entries
    for (int k = 0; k < 4; k++) begin
      int j;
      j = $urandom_range(8, 1);
      do_lookup("wrap_rand", 32'(32'h1000 + 4 * j),
                mk(1, 1, 32'(32'h5000 + 4 * j), (j == 8) ? 3'd0 : 3'(j)));
    end
    do_flush();
    do_lookup("flushed_a", 32'h1020, mk(0, 0, 0, 0));
    do_lookup("flushed_b", 32'h1004, mk(0, 0, 0, 0));
    wait_drain();

    // reset drops a pending response
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("pend_before_rst", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_drop_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_drop_vec", 64'({resp_hit, resp_taken, resp_target, resp_idx}), 64'd0);
    resp_ready = 1'b1;
    do_lookup("post_rst_lookup", 32'h1004, mk(0, 0, 0, 0));
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
